// File: rtl/eth_tx_ctrl.sv
// RMII transmit framer: preamble/SFD, FIFO payload, zero padding, FCS from an
// external CRC generator, then inter-frame gap. One byte per 4 Clk cycles.
module eth_tx_ctrl #(
    parameter int MIN_FRAME = 60,
    parameter int MAX_FRAME = 1514,
    parameter int IFG_BYTES = 12
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Tx_Start,
    input  logic [10:0] Tx_Len,
    output logic        Fifo_Rd,
    input  logic [7:0]  Fifo_Data,
    output logic        Crc_Req,
    output logic        Byte_Rdy,
    output logic [7:0]  Byte,
    input  logic [31:0] Crc_Out,
    output logic        Tx_En,
    output logic [1:0]  Txd,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);
    localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);
    localparam logic [10:0] MIN_LAST = 11'(MIN_FRAME - 1);
    localparam logic [10:0] MAX_LEN  = 11'(MAX_FRAME);
    localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);
    localparam logic [10:0] PRE_LAST = 11'd6;
    localparam logic [10:0] FCS_LAST = 11'd3;

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt;
    logic [10:0] byte_cnt;
    logic [10:0] len;
    logic [7:0]  cur_byte;
    logic [31:0] fcs_sh;
    logic        done_q, err_q;
    logic        len_ok, accept, reject, byte_end, last_data, need_pad;

    assign len_ok    = (Tx_Len != 11'd0) && (Tx_Len <= MAX_LEN);
    assign accept    = (state == IDLE) && Tx_Start && len_ok;
    assign reject    = (state == IDLE) && Tx_Start && !len_ok;
    assign byte_end  = (cnt == 2'd3);
    assign last_data = (byte_cnt == len - 11'd1);
    assign need_pad  = (len < MIN_LEN);
    assign Busy      = (state != IDLE);
    assign Done      = done_q;
    assign Err       = err_q;

    always_ff @(posedge Clk) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Tx_En     = 1'b0;
        Txd       = 2'b00;
        Fifo_Rd   = 1'b0;
        Crc_Req   = 1'b0;
        Byte_Rdy  = 1'b0;
        Byte      = 8'h00;
        case (state)
            IDLE: if (accept) state_nxt = PRE;
            PRE: begin
                Tx_En = 1'b1;
                Txd   = 2'b01;
                if (byte_end && byte_cnt == PRE_LAST) state_nxt = SFD;
            end
            SFD: begin
                Tx_En   = 1'b1;
                Txd     = byte_end ? 2'b11 : 2'b01;
                Fifo_Rd = (cnt == 2'd1);
                if (byte_end) state_nxt = DATA;
            end
            DATA: begin
                Tx_En    = 1'b1;
                Txd      = cur_byte[{cnt, 1'b0} +: 2];
                Crc_Req  = 1'b1;
                Byte_Rdy = (cnt == 2'd0);
                Byte     = cur_byte;
                // Prefetch the next payload byte; none after the last one.
                Fifo_Rd  = (cnt == 2'd1) && !last_data;
                if (byte_end && last_data) state_nxt = need_pad ? PAD : FCS;
            end
            PAD: begin
                Tx_En    = 1'b1;
                Txd      = cur_byte[{cnt, 1'b0} +: 2];
                Crc_Req  = 1'b1;
                Byte_Rdy = (cnt == 2'd0);
                Byte     = cur_byte;
                if (byte_end && byte_cnt == MIN_LAST) state_nxt = FCS;
            end
            FCS: begin
                Tx_En   = 1'b1;
                Txd     = cur_byte[{cnt, 1'b0} +: 2];
                Crc_Req = 1'b1;
                if (byte_end && byte_cnt == FCS_LAST) state_nxt = IFG;
            end
            IFG: if (byte_end && byte_cnt == IFG_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            cnt      <= '0;
            byte_cnt <= '0;
            len      <= '0;
            cur_byte <= '0;
            fcs_sh   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= reject;
            if (state == IDLE) begin
                cnt      <= '0;
                byte_cnt <= '0;
                if (accept) len <= Tx_Len;
            end else begin
                cnt <= cnt + 2'd1;
                if (byte_end) begin
                    case (state)
                        PRE: byte_cnt <= (byte_cnt == PRE_LAST) ? 11'd0 : byte_cnt + 11'd1;
                        SFD: begin
                            cur_byte <= Fifo_Data;
                            byte_cnt <= '0;
                        end
                        DATA: begin
                            if (!last_data) begin
                                cur_byte <= Fifo_Data;
                                byte_cnt <= byte_cnt + 11'd1;
                            end else if (need_pad) begin
                                // Pad bytes continue the count up to MIN_FRAME-1.
                                cur_byte <= 8'h00;
                                byte_cnt <= byte_cnt + 11'd1;
                            end else begin
                                cur_byte <= Crc_Out[7:0];
                                fcs_sh   <= Crc_Out;
                                byte_cnt <= '0;
                            end
                        end
                        PAD: begin
                            if (byte_cnt == MIN_LAST) begin
                                cur_byte <= Crc_Out[7:0];
                                fcs_sh   <= Crc_Out;
                                byte_cnt <= '0;
                            end else begin
                                byte_cnt <= byte_cnt + 11'd1;
                            end
                        end
                        FCS: begin
                            if (byte_cnt == FCS_LAST) begin
                                byte_cnt <= '0;
                            end else begin
                                cur_byte <= fcs_sh[15:8];
                                fcs_sh   <= {8'h00, fcs_sh[31:8]};
                                byte_cnt <= byte_cnt + 11'd1;
                            end
                        end
                        IFG: begin
                            if (byte_cnt == IFG_LAST) begin
                                byte_cnt <= '0;
                                done_q   <= 1'b1;
                            end else begin
                                byte_cnt <= byte_cnt + 11'd1;
                            end
                        end
                        default: byte_cnt <= '0;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_eth_tx_ctrl.sv
// Bench for eth_tx_ctrl: FIFO and CRC-generator models around the DUT, plus a
// frame-timeline reference model compared against every output each cycle.
module tb_eth_tx_ctrl;
    localparam int MIN_FRAME = 60;
    localparam int MAX_FRAME = 1514;
    localparam int IFG_BYTES = 12;

    logic        Clk, Rst, Tx_Start;
    logic [10:0] Tx_Len;
    logic        Fifo_Rd;
    logic [7:0]  Fifo_Data;
    logic        Crc_Req, Byte_Rdy;
    logic [7:0]  Byte;
    logic [31:0] Crc_Out;
    logic        Tx_En;
    logic [1:0]  Txd;
    logic        Busy, Done, Err;

    eth_tx_ctrl #(.MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME), .IFG_BYTES(IFG_BYTES)) dut (
        .Clk(Clk), .Rst(Rst), .Tx_Start(Tx_Start), .Tx_Len(Tx_Len),
        .Fifo_Rd(Fifo_Rd), .Fifo_Data(Fifo_Data), .Crc_Req(Crc_Req),
        .Byte_Rdy(Byte_Rdy), .Byte(Byte), .Crc_Out(Crc_Out), .Tx_En(Tx_En),
        .Txd(Txd), .Busy(Busy), .Done(Done), .Err(Err)
    );

    initial begin
        Clk = 1'b0;
        forever #10 Clk = ~Clk;
    end

    typedef struct packed {
        logic       tx_en;
        logic [1:0] txd;
        logic       fifo_rd;
        logic       byte_rdy;
        logic [7:0] bval;
        logic       crc_req;
        logic       busy;
        logic       done;
        logic       err;
    } rec_t;

    logic [7:0]  mem [0:2047];
    logic [10:0] rd_ptr;
    logic [31:0] gen_crc;
    rec_t        exp_q [$];
    rec_t        exp_r, got_r;

    int checks, errors, cyc;
    int txen_cnt, rd_cnt, rdy_cnt, done_cnt, err_cnt, rise_cyc, fall_cyc;
    logic prev_en;
    bit started;
    string lit_name;
    int lit_got, lit_exp, lit_seq, lit_seen;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Environment: registered FIFO and CRC generator (Ethernet CRC-32).
    assign Crc_Out = ~gen_crc;
    always @(posedge Clk) begin
        if (Rst !== 1'b1) begin
            rd_ptr    <= '0;
            Fifo_Data <= '0;
            gen_crc   <= '1;
        end else begin
            if (Fifo_Rd === 1'b1) begin
                Fifo_Data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 11'd1;
            end
            if (Crc_Req !== 1'b1)       gen_crc <= '1;
            else if (Byte_Rdy === 1'b1) gen_crc <= crc_byte(gen_crc, Byte);
        end
    end

    // Whole-frame expected timeline, one record per clock after acceptance.
    function automatic void push_frame(input int len);
        logic [7:0]  b [$];
        logic [31:0] c;
        rec_t        r;
        int          n_body;
        for (int i = 0; i < len; i++) b.push_back(mem[rd_ptr + 11'(i)]);
        while (b.size() < MIN_FRAME) b.push_back(8'h00);
        n_body = b.size();
        c = '1;
        foreach (b[i]) c = crc_byte(c, b[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) b.push_back(c[8*i +: 8]);
        for (int i = 0; i < 28; i++) begin
            r = '0; r.tx_en = 1'b1; r.busy = 1'b1; r.txd = 2'b01;
            exp_q.push_back(r);
        end
        for (int k = 0; k < 4; k++) begin
            r = '0; r.tx_en = 1'b1; r.busy = 1'b1;
            r.txd = (k == 3) ? 2'b11 : 2'b01;
            r.fifo_rd = (k == 1);
            exp_q.push_back(r);
        end
        for (int i = 0; i < b.size(); i++) begin
            for (int k = 0; k < 4; k++) begin
                r = '0; r.tx_en = 1'b1; r.busy = 1'b1; r.crc_req = 1'b1;
                r.txd = 2'(b[i] >> (2 * k));
                if (k == 0 && i < n_body) begin
                    r.byte_rdy = 1'b1;
                    r.bval = b[i];
                end
                r.fifo_rd = (k == 1) && (i < len - 1);
                exp_q.push_back(r);
            end
        end
        for (int i = 0; i < 4 * IFG_BYTES; i++) begin
            r = '0; r.busy = 1'b1;
            exp_q.push_back(r);
        end
        r = '0; r.done = 1'b1;
        exp_q.push_back(r);
    endfunction

    // Compare process: checks DUT against the model every cycle.
    initial begin
        checks = 0; errors = 0; cyc = 0; lit_seen = 0;
        txen_cnt = 0; rd_cnt = 0; rdy_cnt = 0; done_cnt = 0; err_cnt = 0;
        rise_cyc = 0; fall_cyc = 0; prev_en = 1'b0;
        forever begin
            @(negedge Clk);
            if (started) begin
                exp_r = '0;
                if (exp_q.size() > 0) exp_r = exp_q.pop_front();
                got_r = {Tx_En, Txd, Fifo_Rd, Byte_Rdy, (exp_r.byte_rdy ? Byte : 8'h00),
                         Crc_Req, Busy, Done, Err};
                checks++;
                if (got_r !== exp_r) begin
                    errors++;
                    $display("FAIL cycle_check cyc=%0d got en=%b txd=%b rd=%b rdy=%b byte=%h crcreq=%b busy=%b done=%b err=%b required en=%b txd=%b rd=%b rdy=%b byte=%h crcreq=%b busy=%b done=%b err=%b",
                             cyc, got_r.tx_en, got_r.txd, got_r.fifo_rd, got_r.byte_rdy, got_r.bval,
                             got_r.crc_req, got_r.busy, got_r.done, got_r.err,
                             exp_r.tx_en, exp_r.txd, exp_r.fifo_rd, exp_r.byte_rdy, exp_r.bval,
                             exp_r.crc_req, exp_r.busy, exp_r.done, exp_r.err);
                end
                if (Tx_En === 1'b1) txen_cnt++;
                if (Fifo_Rd === 1'b1) rd_cnt++;
                if (Byte_Rdy === 1'b1) rdy_cnt++;
                if (Done === 1'b1) done_cnt++;
                if (Err === 1'b1) err_cnt++;
                if (Tx_En === 1'b1 && !prev_en) rise_cyc = cyc;
                if (Tx_En !== 1'b1 && prev_en) fall_cyc = cyc;
                prev_en = (Tx_En === 1'b1);
                if (Rst !== 1'b1) begin
                    exp_q.delete();
                end else if (!exp_r.busy && Tx_Start) begin
                    if (Tx_Len >= 11'd1 && int'(Tx_Len) <= MAX_FRAME) begin
                        push_frame(int'(Tx_Len));
                    end else begin
                        exp_r = '0; exp_r.err = 1'b1;
                        exp_q.push_back(exp_r);
                    end
                end
                if (lit_seq != lit_seen) begin
                    lit_seen = lit_seq;
                    checks++;
                    if (lit_got !== lit_exp) begin
                        errors++;
                        $display("FAIL %s got %0d (0x%h) required %0d (0x%h)",
                                 lit_name, lit_got, lit_got, lit_exp, lit_exp);
                    end
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic lit(input string nm, input int got, input int req);
        lit_name = nm;
        lit_got  = got;
        lit_exp  = req;
        lit_seq++;
        tick();
    endtask

    task automatic load(input int len, input bit rnd);
        for (int i = 0; i < len; i++) mem[rd_ptr + 11'(i)] = rnd ? 8'($urandom) : 8'(i);
    endtask

    task automatic send(input int len);
        Tx_Len   = 11'(len);
        Tx_Start = 1'b1;
        tick();
        Tx_Start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == d0) lit("done_timeout", done_cnt - d0, 1);
    endtask

    task automatic frame_test(input string nm, input int len, input bit rnd,
                              input int exp_en, input int exp_rd, input int exp_rdy);
        int e0, r0, y0, d0;
        e0 = txen_cnt; r0 = rd_cnt; y0 = rdy_cnt; d0 = done_cnt;
        load(len, rnd);
        send(len);
        wait_done(7000);
        lit({nm, "_txen"}, txen_cnt - e0, exp_en);
        lit({nm, "_fiford"}, rd_cnt - r0, exp_rd);
        lit({nm, "_byterdy"}, rdy_cnt - y0, exp_rdy);
        lit({nm, "_done"}, done_cnt - d0, 1);
    endtask

    task automatic reject_test(input string nm, input int len);
        int e0, t0;
        e0 = err_cnt; t0 = txen_cnt;
        send(len);
        tick();
        tick();
        lit({nm, "_err"}, err_cnt - e0, 1);
        lit({nm, "_txen"}, txen_cnt - t0, 0);
        lit({nm, "_busy"}, int'(Busy), 0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c;
        string s;
        int d0, e0, r0, len, el;
        Rst = 1'b0; Tx_Start = 1'b0; Tx_Len = '0; started = 1'b0; lit_seq = 0;
        repeat (3) tick();
        started = 1'b1;
        tick();
        Rst = 1'b1;
        tick();
        lit("rst_busy", int'(Busy), 0);
        lit("rst_txen", int'(Tx_En), 0);

        s = "123456789";
        c = '1;
        for (int i = 0; i < s.len(); i++) c = crc_byte(c, s[i]);
        lit("crc_ref", int'(~c), int'(32'hCBF43926));

        frame_test("len60", 60, 1'b0, 288, 60, 60);
        frame_test("len10", 10, 1'b1, 288, 10, 60);
        frame_test("len59", 59, 1'b1, 288, 59, 60);
        frame_test("len61", 61, 1'b1, 292, 61, 61);
        frame_test("len1", 1, 1'b1, 288, 1, 60);
        frame_test("len1514", 1514, 1'b1, 6104, 1514, 1514);
        reject_test("len0", 0);
        reject_test("len1515", 1515);

        // Start request in the middle of DATA must be ignored.
        d0 = done_cnt; e0 = txen_cnt; r0 = rd_cnt; el = err_cnt;
        load(40, 1'b1);
        send(40);
        repeat (60) tick();
        Tx_Len = 11'd5; Tx_Start = 1'b1;
        tick();
        Tx_Start = 1'b0;
        wait_done(7000);
        lit("busy_start_done", done_cnt - d0, 1);
        lit("busy_start_fiford", rd_cnt - r0, 40);
        lit("busy_start_txen", txen_cnt - e0, 288);
        lit("busy_start_err", err_cnt - el, 0);

        // Reset at DATA byte 20 aborts the frame.
        d0 = done_cnt;
        load(70, 1'b1);
        send(70);
        repeat (112) tick();
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        lit("abort_txen", int'(Tx_En), 0);
        lit("abort_busy", int'(Busy), 0);
        lit("abort_crcreq", int'(Crc_Req), 0);
        repeat (60) tick();
        lit("abort_done", done_cnt - d0, 0);
        frame_test("after_rst", 64, 1'b1, 304, 64, 64);

        // Back-to-back frames with Tx_Start held through Done.
        d0 = done_cnt;
        load(40, 1'b1);
        Tx_Len = 11'd20; Tx_Start = 1'b1;
        wait_done(7000);
        Tx_Start = 1'b0;
        tick();
        lit("ifg_gap", rise_cyc - fall_cyc, 49);
        wait_done(7000);
        lit("b2b_done", done_cnt - d0, 2);

        for (int t = 0; t < 10; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                reject_test("rnd_reject", int'($urandom_range(1515, 2047)));
            end else begin
                len = int'($urandom_range(1, 130));
                d0 = done_cnt; e0 = txen_cnt; r0 = rd_cnt;
                load(len, 1'b1);
                send(len);
                repeat ($urandom_range(1, 200)) tick();
                if (Busy === 1'b1) begin
                    Tx_Len = 11'($urandom);
                    Tx_Start = 1'b1;
                    tick();
                    Tx_Start = 1'b0;
                end
                wait_done(7000);
                lit("rnd_txen", txen_cnt - e0, 4 * (12 + ((len > MIN_FRAME) ? len : MIN_FRAME)));
                lit("rnd_fiford", rd_cnt - r0, len);
                lit("rnd_done", done_cnt - d0, 1);
            end
        end

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/eth_tx_ctrl.md
ETH_TX_CTRL -- requirements
Module: eth_tx_ctrl

Interface
REQ-001 Parameter MIN_FRAME, default 60, minimum bytes before FCS (short frames padded with 0x00).
REQ-002 Parameter MAX_FRAME, default 1514, maximum Tx_Len accepted.
REQ-003 Parameter IFG_BYTES, default 12, inter-frame gap in byte times.
REQ-004 Clk  in  1  50 MHz RMII reference clock; all logic on posedge Clk.
REQ-005 Rst  in  1  synchronous active-low reset, sampled on posedge Clk.
REQ-006 Tx_Start  in  1  one-cycle request to send a frame; Tx_Len sampled same cycle.
REQ-007 Tx_Len  in  11  frame bytes excluding preamble/SFD/FCS (DA..payload).
REQ-008 Fifo_Rd  out  1  one-cycle pop strobe to the TX byte FIFO.
REQ-009 Fifo_Data  in  8  FIFO byte, valid from the cycle after Fifo_Rd until the next Fifo_Rd.
REQ-010 Crc_Req  out  1  CRC generator enable/hold; low clears the generator.
REQ-011 Byte_Rdy  out  1  one-cycle strobe, Byte valid for CRC accumulation.
REQ-012 Byte  out  8  byte presented to CRC generator.
REQ-013 Crc_Out  in  32  final FCS from CRC generator, valid at most 3 cycles after the last Byte_Rdy.
REQ-014 Tx_En  out  1  RMII transmit enable.
REQ-015 Txd  out  2  RMII dibit, LSB pair first within each byte.
REQ-016 Busy  out  1  high from frame acceptance until end of IFG.
REQ-017 Done  out  1  one-cycle pulse at end of IFG.
REQ-018 Err  out  1  one-cycle pulse when Tx_Start is rejected for length.

Function
REQ-019 States SHALL be IDLE, PRE, SFD, DATA, PAD, FCS, IFG; one byte = 4 Clk cycles, dibit counter 0..3, Txd = byte[2k+1:2k] at count k.
REQ-020 IDLE: Tx_Start=1 with 1<=Tx_Len<=MAX_FRAME -> PRE next cycle, latch Tx_Len, Busy=1; otherwise Err pulse next cycle, stay IDLE.
REQ-021 Tx_Start while Busy=1 SHALL be ignored (no Err, no effect).
REQ-022 PRE: 7 bytes 0x55 (Txd=2'b01 for 28 cycles), Tx_En=1 from first PRE cycle.
REQ-023 SFD: 1 byte 0xD5 (dibits 01,01,01,11).
REQ-024 Fifo_Rd SHALL pulse at dibit count 1 of the byte preceding each DATA byte (first pulse in SFD); Fifo_Data latched into the shift register at dibit count 3.
REQ-025 DATA: Tx_Len bytes from FIFO; exactly Tx_Len Fifo_Rd pulses per frame.
REQ-026 PAD: entered after DATA only if Tx_Len<MIN_FRAME; sends MIN_FRAME-Tx_Len bytes 0x00; no Fifo_Rd.
REQ-027 Byte_Rdy SHALL pulse at dibit count 0 of every DATA and PAD byte with Byte = byte being sent; never in PRE/SFD/FCS.
REQ-028 Crc_Req SHALL be 1 from first DATA cycle through last FCS cycle, 0 otherwise.
REQ-029 FCS: Crc_Out latched at FCS entry; bytes Crc_Out[7:0],[15:8],[23:16],[31:24] sent in order.
REQ-030 Tx_En SHALL drop to 0 and Txd to 2'b00 the cycle after the last FCS dibit; total Tx_En-high cycles = 4*(8+max(Tx_Len,MIN_FRAME)+4).
REQ-031 IFG: 4*IFG_BYTES cycles with Tx_En=0; Done pulse and Busy=0 on the cycle returning to IDLE; Tx_Start accepted that next IDLE cycle.
REQ-032 Byte counter SHALL be 11 bits, no wrap within a legal frame.

Reset
REQ-033 Rst=0 SHALL force IDLE next edge: Tx_En=0, Txd=0, Fifo_Rd=0, Byte_Rdy=0, Byte=0, Crc_Req=0, Busy=0, Done=0, Err=0, counters 0.
REQ-034 Reset mid-frame SHALL abort immediately (no FCS, no IFG, no Done); FIFO flush is the owner's responsibility.

Verification
REQ-035 Tx_Len=60, FIFO bytes 0x00..0x3B -> 28 cycles Txd=01, SFD, 60 bytes, no PAD, FCS=0x7D..., Tx_En high 288 cycles, 60 Fifo_Rd, 60 Byte_Rdy.
REQ-036 Tx_Len=10 -> 10 Fifo_Rd, 50 pad bytes 0x00, 60 Byte_Rdy, Tx_En high 288 cycles, FCS matches reference CRC over 60 bytes.
REQ-037 Tx_Len=0 and Tx_Len=1515 -> Err pulse, Tx_En stays 0, Busy stays 0.
REQ-038 Tx_Start pulsed during DATA -> ignored; frame completes unchanged, one Done.
REQ-039 Rst=0 at DATA byte 20 -> next cycle Tx_En=0, Busy=0, Crc_Req=0; no Done; new Tx_Start after release sends full frame.
REQ-040 Tx_Start held at Done cycle+1 -> Tx_En re-rises exactly 48 cycles (IFG_BYTES=12) after previous Tx_En fall plus 1.
